// File: rtl/ctrl_pipe_div.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe_div
//  Brief    : Decoded control-word pipeline (E, M, W, ...) with stall/flush
//             bubbles and a multicycle-divide hold FSM for stage E.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_div #(
    parameter int CW      = 12,
    parameter int STAGES  = 3,
    parameter int DIV_LAT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CW-1:0]          ctrl_d,
    input  logic                   valid_d,
    input  logic                   div_d,
    input  logic                   stall_d,
    input  logic                   flush_e,
    output logic [STAGES*CW-1:0]   ctrl_q,
    output logic [STAGES-1:0]      valid_q,
    output logic                   div_busy,
    output logic                   div_done
);

    localparam int              CNT_W     = $clog2(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_LAT - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [STAGES-1:0][CW-1:0] stg_ctrl_q, stg_ctrl_d;
    logic [STAGES-1:0]        stg_valid_q, stg_valid_d;
    logic                     div_flag_q, div_flag_d;

    logic div_e;
    logic last_cycle;
    logic hold_e;
    logic kill_m;

    assign div_e      = stg_valid_q[0] & div_flag_q;
    assign last_cycle = (state_q == ST_BUSY) && (cnt_q == '0);
    assign hold_e     = div_e & ~last_cycle & ~flush_e;
    // A divide leaves E only after its final cycle; aborted divides never reach M.
    assign kill_m     = hold_e | (div_e & flush_e);

    assign div_busy = hold_e;
    assign div_done = div_e & last_cycle & ~flush_e;

    assign ctrl_q  = stg_ctrl_q;
    assign valid_q = stg_valid_q;

    always_comb begin
        stg_ctrl_d  = stg_ctrl_q;
        stg_valid_d = stg_valid_q;
        div_flag_d  = div_flag_q;

        if (flush_e) begin
            stg_ctrl_d[0]  = '0;
            stg_valid_d[0] = 1'b0;
            div_flag_d     = 1'b0;
        end else if (!hold_e) begin
            if (stall_d) begin
                stg_ctrl_d[0]  = '0;
                stg_valid_d[0] = 1'b0;
                div_flag_d     = 1'b0;
            end else begin
                stg_ctrl_d[0]  = ctrl_d;
                stg_valid_d[0] = valid_d;
                div_flag_d     = div_d & valid_d;
            end
        end

        if (kill_m) begin
            stg_ctrl_d[1]  = '0;
            stg_valid_d[1] = 1'b0;
        end else begin
            stg_ctrl_d[1]  = stg_ctrl_q[0];
            stg_valid_d[1] = stg_valid_q[0];
        end

        for (int k = 2; k < STAGES; k++) begin
            stg_ctrl_d[k]  = stg_ctrl_q[k-1];
            stg_valid_d[k] = stg_valid_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (div_e && !flush_e) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_START;
                end
            end
            ST_BUSY: begin
                if (flush_e || (cnt_q == '0)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stg_ctrl_q  <= '0;
            stg_valid_q <= '0;
            div_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stg_ctrl_q  <= stg_ctrl_d;
            stg_valid_q <= stg_valid_d;
            div_flag_q  <= div_flag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_pipe_div
//  Brief    : Directed scenarios plus randomized traffic against a cycle-level
//             occupancy model of the control pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_div;

    localparam int CW  = 12;
    localparam int NS  = 3;
    localparam int LAT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [CW-1:0]      ctrl_d;
    logic               valid_d;
    logic               div_d;
    logic               stall_d;
    logic               flush_e;
    logic [NS*CW-1:0]   ctrl_q;
    logic [NS-1:0]      valid_q;
    logic               div_busy;
    logic               div_done;

    always #5 clk = ~clk;

    ctrl_pipe_div #(.CW(CW), .STAGES(NS), .DIV_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_d   (ctrl_d),
        .valid_d  (valid_d),
        .div_d    (div_d),
        .stall_d  (stall_d),
        .flush_e  (flush_e),
        .ctrl_q   (ctrl_q),
        .valid_q  (valid_q),
        .div_busy (div_busy),
        .div_done (div_done)
    );

    int total = 0;
    int bad   = 0;

    // Observed outputs and model expectations for the most recent cycle
    logic [NS*CW-1:0] o_ctrl, e_ctrl;
    logic [NS-1:0]    o_valid, e_valid;
    logic             o_busy, e_busy, o_done, e_done;

    // Model: what each stage holds, whether E holds a divide, and how long it has sat there
    logic [CW-1:0] m_ctrl [NS];
    logic          m_val  [NS];
    logic          m_div;
    int            m_age;

    task automatic tick(input logic [CW-1:0] c, input logic v, input logic dv,
                        input logic st, input logic fl, input logic r);
        logic ediv;
        ctrl_d = c; valid_d = v; div_d = dv; stall_d = st; flush_e = fl; rst = r;
        #1;
        o_ctrl = ctrl_q; o_valid = valid_q; o_busy = div_busy; o_done = div_done;
        ediv   = m_val[0] && m_div;
        e_busy = ediv && !fl && (m_age < LAT - 1);
        e_done = ediv && !fl && (m_age == LAT - 1);
        for (int k = 0; k < NS; k++) begin
            e_ctrl[k*CW +: CW] = m_ctrl[k];
            e_valid[k]         = m_val[k];
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < NS; k++) begin m_ctrl[k] = '0; m_val[k] = 1'b0; end
            m_div = 1'b0; m_age = 0;
        end else begin
            for (int k = NS - 1; k >= 2; k--) begin
                m_ctrl[k] = m_ctrl[k-1]; m_val[k] = m_val[k-1];
            end
            if (ediv && (e_busy || fl)) begin
                m_ctrl[1] = '0; m_val[1] = 1'b0;
            end else begin
                m_ctrl[1] = m_ctrl[0]; m_val[1] = m_val[0];
            end
            if (fl || (st && !e_busy)) begin
                m_ctrl[0] = '0; m_val[0] = 1'b0; m_div = 1'b0; m_age = 0;
            end else if (e_busy) begin
                m_age = m_age + 1;
            end else begin
                m_ctrl[0] = c; m_val[0] = v; m_div = dv && v; m_age = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        tick('0, 0, 0, 0, 0, 1);
        tick(12'h3FF, 1, 1, 0, 0, 1);
        idle(1);
        total++; if (o_ctrl !== '0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", o_ctrl); end
        total++; if (o_valid !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=000", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    endtask

    task automatic test_streaming;
        idle(6);
        tick(12'h001, 1, 0, 0, 0, 0);
        tick(12'h002, 1, 0, 0, 0, 0);
        total++; if (o_ctrl[CW-1:0] !== 12'h001) begin bad++; $display("FAIL stream_e got=%h exp=001", o_ctrl[CW-1:0]); end
        tick(12'h003, 1, 0, 0, 0, 0);
        total++; if (o_ctrl[2*CW-1:CW] !== 12'h001) begin bad++; $display("FAIL stream_m got=%h exp=001", o_ctrl[2*CW-1:CW]); end
        idle(1);
        total++; if (o_ctrl[3*CW-1:2*CW] !== 12'h001) begin bad++; $display("FAIL stream_w got=%h exp=001", o_ctrl[3*CW-1:2*CW]); end
        total++; if (o_valid !== 3'b111) begin bad++; $display("FAIL stream_valid got=%b exp=111", o_valid); end
        total++; if (o_ctrl[CW-1:0] !== 12'h003) begin bad++; $display("FAIL stream_e3 got=%h exp=003", o_ctrl[CW-1:0]); end
    endtask

    task automatic test_stall;
        idle(4);
        tick(12'h011, 1, 0, 0, 0, 0);
        tick(12'h0A5, 1, 0, 1, 0, 0);
        total++; if (o_ctrl[CW-1:0] !== 12'h011) begin bad++; $display("FAIL stall_pre got=%h exp=011", o_ctrl[CW-1:0]); end
        tick(12'h0A5, 1, 0, 0, 0, 0);
        total++; if (o_valid[0] !== 1'b0) begin bad++; $display("FAIL stall_bubble got=%b exp=0", o_valid[0]); end
        total++; if (o_ctrl[2*CW-1:CW] !== 12'h011) begin bad++; $display("FAIL stall_m got=%h exp=011", o_ctrl[2*CW-1:CW]); end
        idle(1);
        total++; if (o_ctrl[CW-1:0] !== 12'h0A5 || o_valid !== 3'b101) begin
            bad++; $display("FAIL stall_enter got=%h/%b exp=0a5/101", o_ctrl[CW-1:0], o_valid);
        end
        total++; if (o_ctrl[3*CW-1:2*CW] !== 12'h011) begin bad++; $display("FAIL stall_w got=%h exp=011", o_ctrl[3*CW-1:2*CW]); end
    endtask

    task automatic test_divide;
        idle(6);
        tick(12'h0D1, 1, 1, 0, 0, 0);
        for (int i = 0; i < LAT; i++) begin
            tick(12'h002, 1, 0, 0, 0, 0);
            total++; if (o_busy !== (i < LAT - 1)) begin bad++; $display("FAIL div_busy t1+%0d got=%b", i, o_busy); end
            total++; if (o_done !== (i == LAT - 1)) begin bad++; $display("FAIL div_done t1+%0d got=%b", i, o_done); end
            total++; if (o_ctrl[CW-1:0] !== 12'h0D1) begin bad++; $display("FAIL div_hold t1+%0d got=%h exp=0d1", i, o_ctrl[CW-1:0]); end
            if (i > 0) begin
                total++; if (o_valid[1] !== 1'b0) begin bad++; $display("FAIL div_mbubble t1+%0d got=%b exp=0", i, o_valid[1]); end
            end
        end
        idle(1);
        total++; if (o_ctrl[2*CW-1:CW] !== 12'h0D1 || o_valid[1] !== 1'b1) begin
            bad++; $display("FAIL div_to_m got=%h/%b exp=0d1/1", o_ctrl[2*CW-1:CW], o_valid[1]);
        end
        total++; if (o_ctrl[CW-1:0] !== 12'h002 || o_valid[0] !== 1'b1) begin
            bad++; $display("FAIL div_next_e got=%h/%b exp=002/1", o_ctrl[CW-1:0], o_valid[0]);
        end
    endtask

    task automatic test_back_to_back;
        idle(6);
        tick(12'h0D1, 1, 1, 0, 0, 0);
        repeat (LAT) tick(12'h0D2, 1, 1, 0, 0, 0);
        for (int i = 0; i < LAT; i++) begin
            idle(1);
            total++; if (o_ctrl[CW-1:0] !== 12'h0D2) begin bad++; $display("FAIL b2b_e t1+%0d got=%h exp=0d2", LAT + i, o_ctrl[CW-1:0]); end
            total++; if (o_busy !== (i < LAT - 1)) begin bad++; $display("FAIL b2b_busy t1+%0d got=%b", LAT + i, o_busy); end
            total++; if (o_done !== (i == LAT - 1)) begin bad++; $display("FAIL b2b_done t1+%0d got=%b", LAT + i, o_done); end
        end
        idle(1);
        total++; if (o_ctrl[2*CW-1:CW] !== 12'h0D2) begin bad++; $display("FAIL b2b_m got=%h exp=0d2", o_ctrl[2*CW-1:CW]); end
    endtask

    task automatic test_flush_abort;
        idle(6);
        tick(12'h0D1, 1, 1, 0, 0, 0);
        idle(1);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b exp=1", o_busy); end
        tick('0, 0, 0, 1, 1, 0);
        total++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL flush_comb got=%b%b exp=00", o_busy, o_done); end
        tick(12'h0D3, 1, 1, 0, 0, 0);
        total++; if (o_valid[1:0] !== 2'b00) begin bad++; $display("FAIL flush_bubble got=%b exp=00", o_valid[1:0]); end
        total++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL flush_after got=%b%b exp=00", o_busy, o_done); end
        for (int i = 0; i < LAT; i++) begin
            idle(1);
            total++; if (o_done !== (i == LAT - 1)) begin bad++; $display("FAIL flush_restart_done i=%0d got=%b", i, o_done); end
        end
    endtask

    task automatic test_reset_mid_div;
        idle(6);
        tick(12'h0D1, 1, 1, 0, 0, 0);
        idle(2);
        tick('0, 0, 0, 0, 0, 1);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rstdiv_pre got=%b exp=1", o_busy); end
        for (int i = 0; i < LAT; i++) begin
            idle(1);
            total++; if (o_ctrl !== '0 || o_valid !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                bad++; $display("FAIL rstdiv i=%0d got=%h/%b/%b%b exp=0/000/00", i, o_ctrl, o_valid, o_busy, o_done);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            tick(CW'($urandom), $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 20,
                 $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 8, $urandom_range(199, 0) < 3);
            total++; if (o_ctrl !== e_ctrl) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", i, o_ctrl, e_ctrl); end
            total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, o_valid, e_valid); end
            total++; if (o_busy !== e_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, o_busy, e_busy); end
            total++; if (o_done !== e_done) begin bad++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", i, o_done, e_done); end
        end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_stall;
        test_divide;
        test_back_to_back;
        test_flush_abort;
        test_reset_mid_div;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
